// File: rtl/pwl_pkg.sv
// pwl_pkg: shared types and constants for the PWL waypoint path.
// Used by the waypoint buffer and the PWL generator.
package pwl_pkg;

    localparam int WP_W      = 48;
    localparam int FIELD_W   = 16;
    localparam int DWELL_LSB = 0;
    localparam int SLOPE_LSB = 16;
    localparam int VALUE_LSB = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARMED,
        PLAY,
        DRAIN
    } wp_state_t;

    typedef struct packed {
        logic [FIELD_W-1:0] value;
        logic [FIELD_W-1:0] slope;
        logic [FIELD_W-1:0] dwell;
    } wp_t;

    function automatic wp_t wp_unpack(logic [WP_W-1:0] d);
        return wp_t'(d);
    endfunction

endpackage

// File: rtl/pwl_skid_fifo.sv
// pwl_skid_fifo: 2-entry valid/ready FIFO with synchronous flush.
// Output is taken straight from storage, so it holds steady while stalled.
module pwl_skid_fifo #(
    parameter int W = 49
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wptr;
    logic         rptr;
    logic         push;
    logic         pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= 2'd0;
        end else if (flush) begin
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem[wptr] <= in_data;
                wptr      <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/pwl_wp_buffer.sv
// pwl_wp_buffer: stages a batch of PWL waypoints in block RAM and
// replays it (once or looped) to the PWL generator over valid/ready.
module pwl_wp_buffer #(
    parameter int DEPTH = 512,
    parameter int WP_W  = 48,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WP_W-1:0] in_data,
    input  logic            in_valid,
    input  logic            in_last,
    output logic            in_ready,
    input  logic            run,
    input  logic            halt,
    input  logic            loop_en,
    output logic [WP_W-1:0] out_data,
    output logic            out_valid,
    output logic            out_last,
    input  logic            out_ready,
    output logic            loaded,
    output logic [AW:0]     wp_count,
    output logic            ovf_err
);

    import pwl_pkg::*;

    wp_state_t state, state_n;

    logic [WP_W-1:0] mem [DEPTH];
    logic [WP_W-1:0] rdata;
    logic            rd_last;
    logic            rv;

    logic [AW-1:0] wr_addr, wr_addr_n;
    logic [AW-1:0] rd_addr, rd_addr_n;
    logic [AW-1:0] waddr, raddr;
    logic [AW:0]   wp_count_n, last_idx;
    logic          loaded_n, ovf_n;
    logic          discard, discard_n;
    logic          loop_q, loop_n;
    logic          we, re, flush, at_last;
    logic          hs, pop, space;
    logic [2:0]    occ;

    logic [1:0]    fcount;
    logic          f_in_ready, f_push;
    logic [WP_W:0] f_out;

    assign in_ready = !rst && (state == IDLE || state == LOAD || state == ARMED);
    assign hs       = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    assign last_idx = wp_count - (AW+1)'(1);

    // Issue a read only if the FIFO can still take it after this cycle's pop.
    assign occ   = {1'b0, fcount} + {2'b00, rv} - {2'b00, pop};
    assign space = (occ < 3'd2);

    always_comb begin
        state_n    = state;
        wr_addr_n  = wr_addr;
        rd_addr_n  = rd_addr;
        wp_count_n = wp_count;
        loaded_n   = loaded;
        ovf_n      = ovf_err;
        discard_n  = discard;
        loop_n     = loop_q;
        we         = 1'b0;
        waddr      = wr_addr;
        re         = 1'b0;
        raddr      = rd_addr;
        flush      = 1'b0;
        at_last    = 1'b0;

        unique case (state)
            IDLE, ARMED: begin
                if (hs) begin
                    we        = 1'b1;
                    waddr     = '0;
                    wr_addr_n = AW'(1);
                    loaded_n  = 1'b0;
                    discard_n = 1'b0;
                    if (in_last) begin
                        wp_count_n = (AW+1)'(1);
                        loaded_n   = 1'b1;
                        state_n    = ARMED;
                    end else begin
                        state_n = LOAD;
                    end
                end else if (state == ARMED && run) begin
                    re      = 1'b1;
                    raddr   = '0;
                    loop_n  = loop_en;
                    state_n = PLAY;
                end
            end
            LOAD: begin
                if (hs && discard) begin
                    if (in_last) begin
                        discard_n = 1'b0;
                        wr_addr_n = '0;
                        state_n   = IDLE;
                    end
                end else if (hs) begin
                    we = 1'b1;
                    if (in_last) begin
                        wp_count_n = {1'b0, wr_addr} + (AW+1)'(1);
                        loaded_n   = 1'b1;
                        state_n    = ARMED;
                    end else if (wr_addr == AW'(DEPTH-1)) begin
                        ovf_n     = 1'b1;
                        discard_n = 1'b1;
                    end else begin
                        wr_addr_n = wr_addr + AW'(1);
                    end
                end
            end
            PLAY: begin
                if (halt) begin
                    flush   = 1'b1;
                    state_n = ARMED;
                end else if (space) begin
                    re = 1'b1;
                end
            end
            DRAIN: begin
                if (halt) begin
                    flush   = 1'b1;
                    state_n = ARMED;
                end else if (fcount == 2'd0 && !rv) begin
                    state_n = ARMED;
                end
            end
            default: state_n = IDLE;
        endcase

        if (re) begin
            at_last   = ({1'b0, raddr} == last_idx);
            rd_addr_n = at_last ? '0 : raddr + AW'(1);
            if (at_last && !loop_n) state_n = DRAIN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_addr  <= '0;
            rd_addr  <= '0;
            wp_count <= '0;
            loaded   <= 1'b0;
            ovf_err  <= 1'b0;
            discard  <= 1'b0;
            loop_q   <= 1'b0;
            rv       <= 1'b0;
        end else begin
            state    <= state_n;
            wr_addr  <= wr_addr_n;
            rd_addr  <= rd_addr_n;
            wp_count <= wp_count_n;
            loaded   <= loaded_n;
            ovf_err  <= ovf_n;
            discard  <= discard_n;
            loop_q   <= loop_n;
            rv       <= re;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= in_data;
        if (re) begin
            rdata   <= mem[raddr];
            rd_last <= at_last;
        end
    end

    assign f_push = rv & f_in_ready;

    pwl_skid_fifo #(
        .W(WP_W + 1)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_data  ({rd_last, rdata}),
        .in_valid (f_push),
        .in_ready (f_in_ready),
        .out_data (f_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count    (fcount)
    );

    assign out_data = f_out[WP_W-1:0];
    assign out_last = out_valid & f_out[WP_W];

endmodule

// File: tb/tb_pwl_wp_buffer.sv
// tb_pwl_wp_buffer: directed table plus hand sequences for load,
// playback, looping, halt, overflow and reset of pwl_wp_buffer.
module tb_pwl_wp_buffer;

    localparam int DEPTH = 512;
    localparam logic T = 1'b1;
    localparam logic F = 1'b0;
    localparam logic [47:0] D1 = 48'h000100020003;
    localparam logic [47:0] D2 = 48'h000100020004;
    localparam logic [47:0] D3 = 48'h000100020005;
    localparam logic [47:0] D4 = 48'h000100020006;
    localparam logic [47:0] Z  = 48'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        run = 1'b0;
    logic        halt = 1'b0;
    logic        loop_en = 1'b0;
    logic [47:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready = 1'b1;
    logic        loaded;
    logic [9:0]  wp_count;
    logic        ovf_err;

    int tests = 0;
    int fails = 0;

    pwl_wp_buffer #(.DEPTH(DEPTH), .WP_W(48)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .run      (run),
        .halt     (halt),
        .loop_en  (loop_en),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_last (out_last),
        .out_ready(out_ready),
        .loaded   (loaded),
        .wp_count (wp_count),
        .ovf_err  (ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        il;
        logic        rn;
        logic [47:0] d;
        logic        e_ir;
        logic        e_ov;
        logic        e_ol;
        logic [47:0] e_od;
        logic        e_ld;
        logic [9:0]  e_wc;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(logic iv, logic il, logic rn, logic [47:0] d,
                                logic eir, logic eov, logic eol,
                                logic [47:0] eod, logic eld, logic [9:0] ewc);
        vec_t v;
        v.iv = iv; v.il = il; v.rn = rn; v.d = d;
        v.e_ir = eir; v.e_ov = eov; v.e_ol = eol;
        v.e_od = eod; v.e_ld = eld; v.e_wc = ewc;
        return v;
    endfunction

    task automatic chk1(string nm, logic act, logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chkd(string nm, logic [47:0] act, logic [47:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkn(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic load(int n, logic [47:0] base);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + 48'(i);
            in_last  = (i == n - 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic play(int n, logic [47:0] base, string nm);
        int got = 0;
        run = 1'b1; loop_en = 1'b0; out_ready = 1'b1;
        tick();
        run = 1'b0;
        for (int c = 0; c < n + 10 && got < n; c++) begin
            smp();
            if (out_valid) begin
                chkd($sformatf("%s_data%0d", nm, got), out_data, base + 48'(got));
                chk1($sformatf("%s_last%0d", nm, got), out_last, got == n - 1);
                got++;
            end
            tick();
        end
        chkn($sformatf("%s_count", nm), got, n);
        for (int c = 0; c < 10 && !in_ready; c++) tick();
        chk1($sformatf("%s_armed", nm), in_ready, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int hs;
        logic prev_stall;
        logic [47:0] pd;
        logic pl;
        logic ir_ok;

        tbl[0]  = mk(T, F, F, D1, T, F, F, Z,  F, 10'd0);
        tbl[1]  = mk(T, F, F, D2, T, F, F, Z,  F, 10'd0);
        tbl[2]  = mk(T, F, F, D3, T, F, F, Z,  F, 10'd0);
        tbl[3]  = mk(T, T, F, D4, T, F, F, Z,  F, 10'd0);
        tbl[4]  = mk(F, F, T, Z,  T, F, F, Z,  T, 10'd4);
        tbl[5]  = mk(F, F, F, Z,  F, F, F, Z,  T, 10'd4);
        tbl[6]  = mk(F, F, F, Z,  F, T, F, D1, T, 10'd4);
        tbl[7]  = mk(F, F, F, Z,  F, T, F, D2, T, 10'd4);
        tbl[8]  = mk(F, F, F, Z,  F, T, F, D3, T, 10'd4);
        tbl[9]  = mk(F, F, F, Z,  F, T, T, D4, T, 10'd4);
        tbl[10] = mk(F, F, F, Z,  F, F, F, Z,  T, 10'd4);
        tbl[11] = mk(F, F, F, Z,  T, F, F, Z,  T, 10'd4);

        // reset values
        tick();
        tick();
        smp();
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_out_last", out_last, 1'b0);
        chkd("rst_out_data", out_data, Z);
        chk1("rst_loaded", loaded, 1'b0);
        chkn("rst_wp_count", int'(wp_count), 0);
        chk1("rst_ovf", ovf_err, 1'b0);
        tick();
        rst = 1'b0;

        // load 4, single pass, cycle-exact
        loop_en = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = tbl[i].iv;
            in_last  = tbl[i].il;
            in_data  = tbl[i].d;
            run      = tbl[i].rn;
            smp();
            chk1($sformatf("t%0d_in_ready", i), in_ready, tbl[i].e_ir);
            chk1($sformatf("t%0d_out_valid", i), out_valid, tbl[i].e_ov);
            if (tbl[i].e_ov) begin
                chk1($sformatf("t%0d_out_last", i), out_last, tbl[i].e_ol);
                chkd($sformatf("t%0d_out_data", i), out_data, tbl[i].e_od);
            end
            chk1($sformatf("t%0d_loaded", i), loaded, tbl[i].e_ld);
            chkn($sformatf("t%0d_wp_count", i), int'(wp_count), int'(tbl[i].e_wc));
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0; run = 1'b0;

        // looped playback, out_ready toggling 1010...
        run = 1'b1; loop_en = 1'b1; out_ready = 1'b1;
        tick();
        run = 1'b0; loop_en = 1'b0;
        idx = 0; hs = 0; prev_stall = 1'b0; pd = '0; pl = 1'b0;
        for (int c = 0; c < 40; c++) begin
            out_ready = (c % 2 == 0);
            smp();
            if (prev_stall) begin
                chk1("stall_valid", out_valid, 1'b1);
                chkd("stall_data", out_data, pd);
                chk1("stall_last", out_last, pl);
            end
            if (out_valid && out_ready) begin
                chkd("loop_data", out_data, D1 + 48'(idx));
                chk1("loop_last", out_last, idx == 3);
                idx = (idx + 1) % 4;
                hs++;
            end
            prev_stall = out_valid && !out_ready;
            pd = out_data;
            pl = out_last;
            tick();
        end
        chk1("loop_beats", hs >= 15, 1'b1);

        // halt while stalled, then restart from waypoint 0
        out_ready = 1'b0;
        smp();
        chk1("pre_halt_valid", out_valid, 1'b1);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        smp();
        chk1("halt_valid", out_valid, 1'b0);
        chk1("halt_armed", in_ready, 1'b1);
        chk1("halt_loaded", loaded, 1'b1);
        tick();
        play(4, D1, "replay");

        // single-waypoint batch, looped
        load(1, 48'hABCD12345678);
        smp();
        chkn("single_wp_count", int'(wp_count), 1);
        chk1("single_loaded", loaded, 1'b1);
        tick();
        run = 1'b1; loop_en = 1'b1; out_ready = 1'b1;
        tick();
        run = 1'b0; loop_en = 1'b0;
        tick();
        for (int c = 0; c < 6; c++) begin
            smp();
            chk1("single_valid", out_valid, 1'b1);
            chk1("single_last", out_last, 1'b1);
            chkd("single_data", out_data, 48'hABCD12345678);
            tick();
        end
        halt = 1'b1;
        tick();
        halt = 1'b0;
        smp();
        chk1("single_halt_valid", out_valid, 1'b0);
        tick();

        // exactly DEPTH waypoints
        load(DEPTH, 48'h0);
        smp();
        chkn("full_wp_count", int'(wp_count), DEPTH);
        chk1("full_loaded", loaded, 1'b1);
        chk1("full_ovf", ovf_err, 1'b0);
        tick();
        play(DEPTH, 48'h0, "full");

        // overflow: DEPTH+3 beats, then in_last
        ir_ok = 1'b1;
        for (int i = 0; i < DEPTH + 3; i++) begin
            in_valid = 1'b1;
            in_last  = 1'b0;
            in_data  = 48'(i);
            if (!in_ready) ir_ok = 1'b0;
            tick();
        end
        in_last = 1'b1;
        if (!in_ready) ir_ok = 1'b0;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        chk1("ovf_in_ready_held", ir_ok, 1'b1);
        smp();
        chk1("ovf_err", ovf_err, 1'b1);
        chk1("ovf_loaded", loaded, 1'b0);
        chk1("ovf_idle_ready", in_ready, 1'b1);
        tick();
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int c = 0; c < 4; c++) begin
            smp();
            chk1("ovf_run_ignored", out_valid, 1'b0);
            tick();
        end

        // reset in the middle of looped playback
        load(4, D1);
        run = 1'b1; loop_en = 1'b1; out_ready = 1'b1;
        tick();
        run = 1'b0; loop_en = 1'b0;
        tick(); tick(); tick();
        smp();
        chk1("mid_play_valid", out_valid, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        smp();
        chk1("mrst_out_valid", out_valid, 1'b0);
        chk1("mrst_out_last", out_last, 1'b0);
        chkd("mrst_out_data", out_data, Z);
        chk1("mrst_loaded", loaded, 1'b0);
        chkn("mrst_wp_count", int'(wp_count), 0);
        chk1("mrst_ovf", ovf_err, 1'b0);
        chk1("mrst_in_ready", in_ready, 1'b1);
        tick();
        load(2, 48'h111122223333);
        smp();
        chkn("post_rst_wp_count", int'(wp_count), 2);
        chk1("post_rst_loaded", loaded, 1'b1);
        tick();
        play(2, 48'h111122223333, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
